alu_op_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the 8-bit ALU datapath (`main`). It accepts one operation per valid/ready handshake and decodes it into the ALU's one-hot `in_selector`, `num1`, `num2` and `out_selector` controls. It waits for the ALU's registered operand stage, captures `outputVal`, and returns the result with an error flag on a valid/ready response channel. A result accumulator allows chained operations without round-tripping through the host.

---
 rtl/alu_op_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command sequencer driving the 8-bit ALU: decodes one op per handshake, captures outputVal, returns it.
// Optional overflow reporting in rsp_err is compiled in with ALU_SEQ_OVF_CHECK_EN.
module alu_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [2:0]       in_selector,
  output logic [WIDTH-1:0] num1,
  output logic [WIDTH-1:0] num2,
  output logic [6:0]       out_selector,
  input  logic [WIDTH-1:0] alu_result,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} stateT;

  stateT            stateReg, stateNext;
  logic [2:0]       opReg;
  logic [WIDTH-1:0] aReg, bReg, accReg, dataReg;
  logic             errReg;
  logic [CNT_W-1:0] doneCnt;
  logic             ovf;

`ifdef ALU_SEQ_OVF_CHECK_EN
  logic [WIDTH:0]     sumExt;
  logic [2*WIDTH-1:0] prodExt;

  always_comb begin
    sumExt  = {1'b0, aReg} + {1'b0, bReg};
    prodExt = {{WIDTH{1'b0}}, aReg} * {{WIDTH{1'b0}}, bReg};
    ovf     = 1'b0;
    case (opReg)
      3'd4:    ovf = sumExt[WIDTH];
      3'd5:    ovf = (aReg < bReg);
      3'd6:    ovf = |prodExt[2*WIDTH-1:WIDTH];
      default: ovf = 1'b0;
    endcase
  end
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      opReg    <= '0;
      aReg     <= '0;
      bReg     <= '0;
      accReg   <= '0;
      dataReg  <= '0;
      errReg   <= 1'b0;
      doneCnt  <= '0;
    end else begin
      stateReg <= stateNext;
      case (stateReg)
        IDLE: begin
          if (cmd_valid) begin
            opReg <= cmd_op;
            aReg  <= cmd_chain ? accReg : cmd_a;
            bReg  <= cmd_b;
            // Reserved op skips the ALU entirely; accumulator is left alone.
            if (cmd_op == 3'd7) begin
              dataReg <= '0;
              errReg  <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          dataReg <= alu_result;
          accReg  <= alu_result;
          errReg  <= ovf;
        end
        RESP: begin
          if (rsp_ready) doneCnt <= doneCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext    = stateReg;
    in_selector  = 3'b001;
    num1         = '0;
    num2         = '0;
    out_selector = 7'b1000000;
    case (stateReg)
      IDLE: begin
        if (cmd_valid) stateNext = (cmd_op == 3'd7) ? RESP : ISSUE;
      end
      ISSUE: begin
        in_selector  = 3'b010;
        num1         = aReg;
        num2         = bReg;
        out_selector = 7'b1000000 >> opReg;
        stateNext    = CAPTURE;
      end
      CAPTURE: begin
        out_selector = 7'b1000000 >> opReg;
        stateNext    = RESP;
      end
      RESP: begin
        if (rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign cmd_ready = (stateReg == IDLE);
  assign rsp_valid = (stateReg == RESP);
  assign rsp_data  = dataReg;
  assign rsp_err   = errReg;
  assign done_cnt  = doneCnt;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small registered-operand ALU model attached.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       cmd_chain = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [2:0] in_selector;
  logic [7:0] num1, num2;
  logic [6:0] out_selector;
  logic [7:0] alu_result;
  logic [7:0] done_cnt;

  int total = 0;
  int bad   = 0;
  logic [7:0] expCnt = 8'd0;

`ifdef ALU_SEQ_OVF_CHECK_EN
  localparam logic EXP_MULT_OVF = 1'b1;
`else
  localparam logic EXP_MULT_OVF = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .in_selector(in_selector), .num1(num1), .num2(num2), .out_selector(out_selector),
    .alu_result(alu_result), .done_cnt(done_cnt)
  );

  // ALU model: operand DFFs load on 3'b010, clear on 3'b001, result is combinational.
  logic [7:0]  aluA = 8'h00, aluB = 8'h00;
  logic [15:0] aluProd;
  always @(posedge clk) begin
    if (in_selector == 3'b010) begin
      aluA <= num1;
      aluB <= num2;
    end else if (in_selector == 3'b001) begin
      aluA <= 8'h00;
      aluB <= 8'h00;
    end
  end
  always_comb begin
    aluProd    = {8'h00, aluA} * {8'h00, aluB};
    alu_result = 8'h00;
    case (out_selector)
      7'b1000000: alu_result = aluA & aluB;
      7'b0100000: alu_result = aluA | aluB;
      7'b0010000: alu_result = ~aluA;
      7'b0001000: alu_result = aluA ^ aluB;
      7'b0000100: alu_result = aluA + aluB;
      7'b0000010: alu_result = aluA - aluB;
      7'b0000001: alu_result = aluProd[7:0];
      default:    alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input string name);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    expCnt = expCnt + 8'd1;
    chk({name, " post rsp_valid"}, rsp_valid, 1'b0);
    chk({name, " done_cnt"}, done_cnt, expCnt);
    $display("txn %s: data=%h err=%b done_cnt=%0d", name, rsp_data, rsp_err, done_cnt);
  endtask

  // Full ALU transaction started from IDLE, one sample point per cycle.
  task automatic doOp(input string name, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic chain, input logic [7:0] expN1,
                      input logic [7:0] expN2, input logic [7:0] expData,
                      input logic expErr, input logic [6:0] expSel);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    tick();
    cmd_valid = 1'b0; cmd_chain = 1'b0;
    chk({name, " issue in_sel"}, in_selector, 3'b010);
    chk({name, " issue num1"}, num1, expN1);
    chk({name, " issue num2"}, num2, expN2);
    chk({name, " issue out_sel"}, out_selector, expSel);
    chk({name, " issue cmd_ready"}, cmd_ready, 1'b0);
    tick();
    chk({name, " capture in_sel"}, in_selector, 3'b001);
    chk({name, " capture out_sel"}, out_selector, expSel);
    chk({name, " capture rsp_valid"}, rsp_valid, 1'b0);
    tick();
    chk({name, " rsp_valid"}, rsp_valid, 1'b1);
    chk({name, " rsp_data"}, rsp_data, expData);
    chk({name, " rsp_err"}, rsp_err, expErr);
    handshake(name);
  endtask

  initial begin
    // Reset state
    #1;
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_data", rsp_data, 8'h00);
    chk("reset rsp_err", rsp_err, 1'b0);
    chk("reset done_cnt", done_cnt, 8'd0);
    chk("reset in_sel", in_selector, 3'b001);
    chk("reset num1", num1, 8'h00);
    chk("reset num2", num2, 8'h00);
    chk("reset out_sel", out_selector, 7'b1000000);
    tick(); tick();
    rst = 1'b0;
    tick();

    doOp("add_5_3", 3'd4, 8'h05, 8'h03, 1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 7'b0000100);

    // MULT 0x10*0x10 then a stalled response with a pending command behind it
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_a = 8'h10; cmd_b = 8'h10;
    tick();
    cmd_valid = 1'b0;
    chk("mult issue out_sel", out_selector, 7'b0000001);
    tick(); tick();
    chk("mult rsp_valid", rsp_valid, 1'b1);
    chk("mult rsp_data", rsp_data, 8'h00);
    chk("mult rsp_err", rsp_err, EXP_MULT_OVF);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'h02; cmd_b = 8'h03; cmd_chain = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall rsp_valid", rsp_valid, 1'b1);
      chk("stall rsp_data", rsp_data, 8'h00);
      chk("stall rsp_err", rsp_err, EXP_MULT_OVF);
      chk("stall cmd_ready", cmd_ready, 1'b0);
    end
    handshake("mult");
    chk("after rsp cmd_ready", cmd_ready, 1'b1);
    chk("after rsp in_sel", in_selector, 3'b001);
    tick();
    cmd_valid = 1'b0;
    chk("pending issue in_sel", in_selector, 3'b010);
    chk("pending issue num1", num1, 8'h02);
    chk("pending issue num2", num2, 8'h03);
    tick(); tick();
    chk("pending rsp_data", rsp_data, 8'h05);
    handshake("add_2_3");

    doOp("sub_chain", 3'd5, 8'hAA, 8'h01, 1'b1, 8'h05, 8'h01, 8'h04, 1'b0, 7'b0000010);

    // Reserved op: response next cycle, ALU untouched
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_a = 8'h09; cmd_b = 8'h09;
    tick();
    cmd_valid = 1'b0;
    chk("rsv rsp_valid", rsp_valid, 1'b1);
    chk("rsv rsp_data", rsp_data, 8'h00);
    chk("rsv rsp_err", rsp_err, 1'b1);
    chk("rsv in_sel", in_selector, 3'b001);
    chk("rsv num1", num1, 8'h00);
    handshake("reserved");

    doOp("acc_kept", 3'd4, 8'h77, 8'h00, 1'b1, 8'h04, 8'h00, 8'h04, 1'b0, 7'b0000100);
    doOp("xor", 3'd3, 8'hF0, 8'hFF, 1'b0, 8'hF0, 8'hFF, 8'h0F, 1'b0, 7'b0001000);
    doOp("and", 3'd0, 8'hCC, 8'hAA, 1'b0, 8'hCC, 8'hAA, 8'h88, 1'b0, 7'b1000000);

    // Reset pulsed during ISSUE
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'h11; cmd_b = 8'h22;
    tick();
    cmd_valid = 1'b0;
    chk("rstmid issue in_sel", in_selector, 3'b010);
    rst = 1'b1;
    #1;
    chk("rstmid in_sel", in_selector, 3'b001);
    chk("rstmid num1", num1, 8'h00);
    chk("rstmid num2", num2, 8'h00);
    chk("rstmid out_sel", out_selector, 7'b1000000);
    chk("rstmid cmd_ready", cmd_ready, 1'b1);
    chk("rstmid rsp_valid", rsp_valid, 1'b0);
    chk("rstmid rsp_data", rsp_data, 8'h00);
    chk("rstmid done_cnt", done_cnt, 8'd0);
    expCnt = 8'd0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post rst rsp_valid", rsp_valid, 1'b0);
    end
    doOp("acc_cleared", 3'd4, 8'h55, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 7'b0000100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
